// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_pkg / cdb_arbiter
//
// Producer side of the common data bus. Completed results from NUM_FU
// functional units are buffered in small per-FU FIFOs. Each cycle the
// round-robin arbiter picks at most one non-empty FIFO and broadcasts its head
// on a registered cdb_t. The ROB and reservation stations consume this bus.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush; discards every buffered result
//   fu_valid   per-FU "result presented" strobe
//   fu_result  per-FU result payload (its .valid field is ignored)
//   fu_ready   per-FU "queue not full", decoded from the registered count only
//   cdb        registered broadcast; cdb.valid qualifies the whole struct
//   grant_idx  index of the FU whose result is currently on cdb
//   busy       at least one queue holds a result
//
// Handshake: a result from FU i is taken at a rising edge when
// fu_valid[i] && fu_ready[i] (and no flush). While fu_ready[i] is low the FU
// must hold its result stable. The CDB side has no backpressure. A result
// issued at an edge is on cdb for exactly the following cycle.
// -----------------------------------------------------------------------------
package cdb_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } rvfi_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_tag;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    rvfi_t       rvfi;
  } cdb_t;

endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int QDEPTH = 2,
  localparam int IW    = $clog2(NUM_FU)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  cdb_t [NUM_FU-1:0]        fu_result,
  output logic [NUM_FU-1:0]        fu_ready,
  output cdb_t                     cdb,
  output logic [IW-1:0]            grant_idx,
  output logic                     busy
);

  localparam int AW = $clog2(QDEPTH);
  // One extra pointer bit distinguishes full from empty; count = tail - head.
  localparam int PW = AW + 1;

  logic [PW-1:0]     head  [NUM_FU];
  logic [PW-1:0]     tail  [NUM_FU];
  logic [PW-1:0]     count [NUM_FU];
  cdb_t              mem   [NUM_FU][QDEPTH];

  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;

  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     rr_next;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic [IW:0]       cand;
  logic [PW-1:0]     win_head;
  cdb_t              win_entry;

  // ---------------------------------------------------------------------------
  // Queue status. Readiness and eligibility come from the registered count, so
  // a full queue cannot take a new result in the cycle it is popped, and a
  // result enqueued this cycle is not a candidate until next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      count[i]    = tail[i] - head[i];
      nonempty[i] = (count[i] != '0);
      fu_ready[i] = (count[i] < PW'(QDEPTH));
      push[i]     = fu_valid[i] && fu_ready[i] && !flush;
    end
  end

  assign busy = |nonempty;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first non-empty queue at or after rr_ptr. Scanning the
  // offsets from far to near lets the nearest candidate overwrite the others.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr;
    cand    = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(NUM_FU)) begin
        cand = cand - (IW + 1)'(NUM_FU);
      end
      if (nonempty[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    if (win_vld && !flush) begin
      pop[win_idx] = 1'b1;
    end
  end

  assign rr_next = (win_idx == IW'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    win_head        = head[win_idx];
    win_entry       = mem[win_idx][win_head[AW-1:0]];
    win_entry.valid = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Pointers. Flush empties every queue and outranks any push or pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) tail[i] <= tail[i] + 1'b1;
        if (pop[i])  head[i] <= head[i] + 1'b1;
      end
    end
  end

  // Payload storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem[i][tail[i][AW-1:0]] <= fu_result[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer and registered broadcast. With no winner only the
  // valid bit drops; payload fields and grant_idx keep their last values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cdb       <= '0;
      grant_idx <= '0;
    end else if (flush) begin
      rr_ptr    <= '0;
      cdb.valid <= 1'b0;
    end else if (win_vld) begin
      rr_ptr    <= rr_next;
      cdb       <= win_entry;
      grant_idx <= win_idx;
    end else begin
      cdb.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter (NUM_FU=4, QDEPTH=2). A behavioural model holds one
// queue of results per FU and, per cycle, picks the first non-empty FU at or
// after the round-robin pointer. Directed table rows, hand-written corner
// sequences and random traffic are all compared against it every cycle, and
// the directed parts also carry their own hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NUM_FU = 4;
  localparam int QDEPTH = 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [NUM_FU-1:0] fu_valid = '0;
  cdb_t [NUM_FU-1:0] fu_result = '0;
  logic [NUM_FU-1:0] fu_ready;
  cdb_t              cdb;
  logic [1:0]        grant_idx;
  logic              busy;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(NUM_FU), .QDEPTH(QDEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_result (fu_result),
    .fu_ready  (fu_ready),
    .cdb       (cdb),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  // ---------------- scoreboard state ----------------
  int   errors = 0;
  int   checks = 0;

  cdb_t m_q [NUM_FU][$];
  int   m_rr;
  cdb_t m_cdb;
  int   m_grant;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_FU; i++) m_q[i].delete();
    m_rr    = 0;
    m_cdb   = '0;
    m_grant = 0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic m_edge();
    int   win;
    bit   full [NUM_FU];
    cdb_t h;
    if (flush) begin
      m_reset_queues_only();
      return;
    end
    for (int i = 0; i < NUM_FU; i++) full[i] = (m_q[i].size() >= QDEPTH);
    win = -1;
    for (int k = 0; k < NUM_FU; k++) begin
      if (win < 0 && m_q[(m_rr + k) % NUM_FU].size() > 0) win = (m_rr + k) % NUM_FU;
    end
    if (win >= 0) begin
      h       = m_q[win].pop_front();
      h.valid = 1'b1;
      m_cdb   = h;
      m_grant = win;
      m_rr    = (win + 1) % NUM_FU;
    end else begin
      m_cdb.valid = 1'b0;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_valid[i] && !full[i]) m_q[i].push_back(fu_result[i]);
    end
  endtask

  task automatic m_reset_queues_only();
    for (int i = 0; i < NUM_FU; i++) m_q[i].delete();
    m_rr        = 0;
    m_cdb.valid = 1'b0;
  endtask

  function automatic logic [NUM_FU-1:0] m_ready();
    logic [NUM_FU-1:0] r;
    for (int i = 0; i < NUM_FU; i++) r[i] = (m_q[i].size() < QDEPTH);
    return r;
  endfunction

  function automatic logic m_busy();
    logic b = 1'b0;
    for (int i = 0; i < NUM_FU; i++) if (m_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic check_all();
    chk("cdb", 160'(cdb), 160'(m_cdb));
    chk("grant_idx", 160'(grant_idx), 160'(m_grant));
    chk("fu_ready", 160'(fu_ready), 160'(m_ready()));
    chk("busy", 160'(busy), 160'(m_busy()));
  endtask

  // ---------------- driver tasks ----------------
  function automatic cdb_t mk(input logic [5:0] tag);
    cdb_t r;
    r.valid    = 1'($urandom_range(0, 1));
    r.rob_tag  = tag;
    r.rs1_data = $urandom;
    r.rs2_data = $urandom;
    r.rvfi.pc  = $urandom;
    r.rvfi.insn = $urandom;
    return r;
  endfunction

  // One clock: model sees the driven inputs, DUT clocks, outputs sampled #1 later.
  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    fu_valid = '0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit                pre_reset;
    logic [3:0]        fv;
    logic [3:0][5:0]   tags;
    logic              exp_valid;
    logic [5:0]        exp_tag;
    logic [1:0]        exp_grant;
    logic [3:0]        exp_ready;
    logic              exp_busy;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [5:0] seen [$];
    logic [5:0] b_tags [3];
    int         bi;
    bit         acc;
    bit         ready_checked;

    // single result from FU2, then round-robin over all four, then FU0+FU3
    vt[0]  = '{1, 4'b0100, {6'd0, 6'd5, 6'd0, 6'd0},   0, 6'd0,  2'd0, 4'b1111, 1};
    vt[1]  = '{0, 4'b0000, '0,                         1, 6'd5,  2'd2, 4'b1111, 0};
    vt[2]  = '{0, 4'b0000, '0,                         0, 6'd0,  2'd2, 4'b1111, 0};
    vt[3]  = '{1, 4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 0, 6'd0, 2'd0, 4'b1111, 1};
    vt[4]  = '{0, 4'b0000, '0,                         1, 6'd10, 2'd0, 4'b1111, 1};
    vt[5]  = '{0, 4'b0000, '0,                         1, 6'd11, 2'd1, 4'b1111, 1};
    vt[6]  = '{0, 4'b0000, '0,                         1, 6'd12, 2'd2, 4'b1111, 1};
    vt[7]  = '{0, 4'b0000, '0,                         1, 6'd13, 2'd3, 4'b1111, 0};
    vt[8]  = '{0, 4'b1001, {6'd23, 6'd0, 6'd0, 6'd20}, 0, 6'd0,  2'd3, 4'b1111, 1};
    vt[9]  = '{0, 4'b0000, '0,                         1, 6'd20, 2'd0, 4'b1111, 1};
    vt[10] = '{0, 4'b0000, '0,                         1, 6'd23, 2'd3, 4'b1111, 0};
    vt[11] = '{0, 4'b0000, '0,                         0, 6'd0,  2'd3, 4'b1111, 0};

    // reset state, sampled while rst_n is still low
    m_reset();
    #2;
    chk("reset_cdb", 160'(cdb), 160'(0));
    chk("reset_ready", 160'(fu_ready), 160'(4'b1111));
    chk("reset_busy", 160'(busy), 160'(0));
    chk("reset_grant", 160'(grant_idx), 160'(0));

    for (int n = 0; n < 12; n++) begin
      if (vt[n].pre_reset) do_reset();
      fu_valid = vt[n].fv;
      for (int i = 0; i < NUM_FU; i++) fu_result[i] = mk(vt[n].tags[i]);
      step();
      chk($sformatf("vec%0d_valid", n), 160'(cdb.valid), 160'(vt[n].exp_valid));
      if (vt[n].exp_valid) chk($sformatf("vec%0d_tag", n), 160'(cdb.rob_tag), 160'(vt[n].exp_tag));
      chk($sformatf("vec%0d_grant", n), 160'(grant_idx), 160'(vt[n].exp_grant));
      chk($sformatf("vec%0d_ready", n), 160'(fu_ready), 160'(vt[n].exp_ready));
      chk($sformatf("vec%0d_busy", n), 160'(busy), 160'(vt[n].exp_busy));
    end
    fu_valid = '0;

    // --- asynchronous reset with three results still queued ---
    do_reset();
    fu_valid = 4'b1111;
    for (int i = 0; i < NUM_FU; i++) fu_result[i] = mk(6'(30 + i));
    step();
    fu_valid = '0;
    step();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("midreset_valid", 160'(cdb.valid), 160'(0));
    chk("midreset_ready", 160'(fu_ready), 160'(4'b1111));
    chk("midreset_busy", 160'(busy), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_reset_idle", 160'(cdb.valid), 160'(0));
    end

    // --- FU1 backpressure while competing with FU0 ---
    do_reset();
    b_tags = '{6'd31, 6'd32, 6'd33};
    bi = 0;
    ready_checked = 0;
    seen.delete();
    for (int c = 0; c < 30; c++) begin
      fu_valid[0] = (bi < 3);
      fu_result[0] = mk(6'(40 + c));
      fu_valid[1] = (bi < 3);
      if (bi < 3) fu_result[1].rob_tag = b_tags[bi];
      acc = fu_valid[1] && (m_q[1].size() < QDEPTH);
      step();
      if (acc) begin
        bi++;
        if (bi < 3) fu_result[1] = mk(b_tags[bi]);
      end
      if (bi == 2 && !ready_checked) begin
        ready_checked = 1;
        chk("bp_ready1_low", 160'(fu_ready[1]), 160'(0));
      end
      if (cdb.valid && grant_idx == 2'd1) seen.push_back(cdb.rob_tag);
    end
    fu_valid = '0;
    chk("bp_ready_seen", 160'(ready_checked), 160'(1));
    chk("bp_count", 160'(seen.size()), 160'(3));
    for (int j = 0; j < 3 && j < seen.size(); j++)
      chk($sformatf("bp_order%0d", j), 160'(seen[j]), 160'(b_tags[j]));

    // --- flush drops queued results and the same-cycle enqueue ---
    do_reset();
    fu_valid = 4'b0111;
    for (int i = 0; i < NUM_FU; i++) fu_result[i] = mk(6'(50 + i));
    step();
    flush = 1'b1;
    fu_valid = 4'b0001;
    fu_result[0] = mk(6'd63);
    step();
    flush = 1'b0;
    fu_valid = '0;
    chk("flush_valid", 160'(cdb.valid), 160'(0));
    chk("flush_busy", 160'(busy), 160'(0));
    for (int c = 0; c < 4; c++) begin
      step();
      chk("flush_no_emit", 160'(cdb.valid), 160'(0));
    end

    // --- 20 results streamed through FU3 alone ---
    do_reset();
    seen.delete();
    bi = 0;
    fu_result[3] = mk(6'd0);
    for (int c = 0; c < 60; c++) begin
      fu_valid = (bi < 20) ? 4'b1000 : 4'b0000;
      acc = fu_valid[3] && (m_q[3].size() < QDEPTH);
      step();
      if (acc) begin
        bi++;
        fu_result[3] = mk(6'(bi));
      end
      if (cdb.valid) seen.push_back(cdb.rob_tag);
    end
    fu_valid = '0;
    chk("wrap_count", 160'(seen.size()), 160'(20));
    for (int j = 0; j < 20 && j < seen.size(); j++)
      chk($sformatf("wrap_order%0d", j), 160'(seen[j]), 160'(j));

    // --- random traffic against the model ---
    do_reset();
    for (int c = 0; c < 500; c++) begin
      fu_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_FU; i++) fu_result[i] = mk(6'($urandom_range(0, 63)));
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    flush    = 1'b0;
    fu_valid = '0;
    for (int c = 0; c < 10; c++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
